// File: rtl/mux_pipe.sv
// Registered N:1 channel multiplexer with valid/ready handshake and out-of-range select flagging.
// Define MUX_PIPE_SKID_EN to add a skid entry so that in_ready is a register output.
module mux_pipe #(
    parameter int DATA_W = 16,
    parameter int NUM_IN = 4,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sel_err
);

    localparam logic [SEL_W:0]   NUM_IN_L = (SEL_W + 1)'(NUM_IN);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_IN - 1);

    function automatic logic [DATA_W-1:0] pick_chan(
        input logic [NUM_IN*DATA_W-1:0] bus,
        input logic [SEL_W-1:0]         idx
    );
        logic [DATA_W-1:0] res;
        res = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (idx == SEL_W'(i)) res = bus[i*DATA_W +: DATA_W];
        end
        return res;
    endfunction

    // p0: clamp the select and pick the channel
    logic              err_p0;
    logic [DATA_W-1:0] data_p0;
    logic              acc_p0;

    assign err_p0  = {1'b0, in_sel} >= NUM_IN_L;
    assign data_p0 = pick_chan(in_data, err_p0 ? LAST_SEL : in_sel);
    assign acc_p0  = in_valid && in_ready;

    // p1: output register
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic [SEL_W-1:0]  sel_p1;
    logic              err_p1;

`ifdef MUX_PIPE_SKID_EN
    logic              vld_sk;
    logic [DATA_W-1:0] data_sk;
    logic [SEL_W-1:0]  sel_sk;
    logic              err_sk;
    logic              out_fire;

    assign out_fire = vld_p1 && out_ready;
    // Ready depends only on the registered skid occupancy, never on out_ready.
    assign in_ready = !rst && !vld_sk;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            sel_p1  <= '0;
            err_p1  <= 1'b0;
            vld_sk  <= 1'b0;
            data_sk <= '0;
            sel_sk  <= '0;
            err_sk  <= 1'b0;
        end else if (vld_sk) begin
            if (out_fire) begin
                data_p1 <= data_sk;
                sel_p1  <= sel_sk;
                err_p1  <= err_sk;
                vld_sk  <= 1'b0;
            end
        end else if (!vld_p1 || out_ready) begin
            vld_p1 <= acc_p0;
            if (acc_p0) begin
                data_p1 <= data_p0;
                sel_p1  <= in_sel;
                err_p1  <= err_p0;
            end
        end else if (acc_p0) begin
            data_sk <= data_p0;
            sel_sk  <= in_sel;
            err_sk  <= err_p0;
            vld_sk  <= 1'b1;
        end
    end
`else
    assign in_ready = !rst && (!vld_p1 || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            sel_p1  <= '0;
            err_p1  <= 1'b0;
        end else if (acc_p0) begin
            vld_p1  <= 1'b1;
            data_p1 <= data_p0;
            sel_p1  <= in_sel;
            err_p1  <= err_p0;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end
`endif

    // An item caught by reset is never presented as transferable.
    assign out_valid = vld_p1 && !rst;
    assign out_data  = data_p1;
    assign out_sel   = sel_p1;
    assign sel_err   = err_p1;

endmodule
